// File: rtl/dcache_two_way_pkg.sv
// ---------------------------------------------------------------------------
// dcache_two_way_pkg : shared types for the 2-way, 8-set, 2-word-block dcache
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dcache_two_way_pkg;
  localparam int SETS     = 8;
  localparam int WAYS     = 2;
  localparam int BLKWORDS = 2;
  localparam int IDXW     = 3;
  localparam int TAGW     = 26;

  typedef logic [31:0] word_t;

  typedef struct packed {
    logic [TAGW-1:0] tag;
    logic [IDXW-1:0] idx;
    logic            blkoff;
    logic [1:0]      bytoff;
  } dcachef_t;

  typedef struct packed {
    logic                       valid;
    logic                       dirty;
    logic [TAGW-1:0]            tag;
    word_t [BLKWORDS-1:0]       data;
  } dcache_frame_t;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    WB0        = 4'd1,
    WB1        = 4'd2,
    LD0        = 4'd3,
    LD1        = 4'd4,
    FLUSH_SCAN = 4'd5,
    FLUSH0     = 4'd6,
    FLUSH1     = 4'd7,
    DONE       = 4'd8
  } dcache_state_t;
endpackage

`default_nettype wire

// File: rtl/dcache_two_way_lru.sv
// ---------------------------------------------------------------------------
// dcache_lru : one LRU bit per set; the bit names the way to evict next
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dcache_lru
  import dcache_two_way_pkg::*;
(
  input  logic            CLK,
  input  logic            nRST,
  input  logic [IDXW-1:0] rd_idx,
  output logic            rd_lru,
  input  logic            upd_en,
  input  logic [IDXW-1:0] upd_idx,
  input  logic            upd_val
);
  logic [SETS-1:0] lru;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      lru <= '0;
    end else if (upd_en) begin
      lru[upd_idx] <= upd_val;
    end
  end

  assign rd_lru = lru[rd_idx];
endmodule

`default_nettype wire

// File: rtl/dcache_two_way.sv
// ---------------------------------------------------------------------------
// dcache_two_way : write-back, write-allocate 2-way data cache with halt flush
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dcache_two_way
  import dcache_two_way_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic [31:0] dload
);
  dcache_frame_t   frames [WAYS][SETS];
  dcache_state_t   state, next_state;
  dcachef_t        req;
  logic [TAGW-1:0] miss_tag;
  logic [IDXW-1:0] miss_idx;
  logic            vway;
  word_t           fill0;
  logic [3:0]      cnt;

  logic            req_any, hit0, hit1, hit_any, hit_way, lru_bit, victim;
  logic            flushing, sel_way;
  logic [IDXW-1:0] sel_idx;
  dcache_frame_t   cur, vic;
  logic            unused_bytoff;

  assign req           = dcachef_t'(dmemaddr);
  assign unused_bytoff = ^req.bytoff;
  assign req_any       = dmemREN | dmemWEN;
  assign hit0          = frames[0][req.idx].valid && (frames[0][req.idx].tag == req.tag);
  assign hit1          = frames[1][req.idx].valid && (frames[1][req.idx].tag == req.tag);
  assign hit_any       = hit0 | hit1;
  assign hit_way       = !hit0;
  assign dhit          = (state == IDLE) && req_any && hit_any;
  assign dmemload      = (dhit && !dmemWEN) ? frames[hit_way][req.idx].data[req.blkoff] : '0;

  // Fill an empty way before displacing anything; way 0 first.
  assign victim = !frames[0][req.idx].valid ? 1'b0 :
                  !frames[1][req.idx].valid ? 1'b1 : lru_bit;
  assign vic    = frames[victim][req.idx];

  assign flushing = (state == FLUSH_SCAN) || (state == FLUSH0) || (state == FLUSH1);
  assign sel_way  = flushing ? cnt[3]   : vway;
  assign sel_idx  = flushing ? cnt[2:0] : miss_idx;
  assign cur      = frames[sel_way][sel_idx];

  dcache_lru u_lru (
    .CLK     (CLK),
    .nRST    (nRST),
    .rd_idx  (req.idx),
    .rd_lru  (lru_bit),
    .upd_en  (dhit),
    .upd_idx (req.idx),
    .upd_val (~hit_way)
  );

  always_comb begin
    next_state = state;
    dREN       = 1'b0;
    dWEN       = 1'b0;
    daddr      = '0;
    dstore     = '0;
    flushed    = 1'b0;
    case (state)
      IDLE: begin
        if (halt)
          next_state = FLUSH_SCAN;
        else if (req_any && !hit_any)
          next_state = (vic.valid && vic.dirty) ? WB0 : LD0;
      end
      WB0, FLUSH0: begin
        dWEN   = 1'b1;
        daddr  = {cur.tag, sel_idx, 1'b0, 2'b00};
        dstore = cur.data[0];
        if (!dwait) next_state = (state == WB0) ? WB1 : FLUSH1;
      end
      WB1, FLUSH1: begin
        dWEN   = 1'b1;
        daddr  = {cur.tag, sel_idx, 1'b1, 2'b00};
        dstore = cur.data[1];
        if (!dwait) begin
          if (state == WB1)      next_state = LD0;
          else if (cnt == 4'd15) next_state = DONE;
          else                   next_state = FLUSH_SCAN;
        end
      end
      LD0: begin
        dREN  = 1'b1;
        daddr = {miss_tag, miss_idx, 1'b0, 2'b00};
        if (!dwait) next_state = LD1;
      end
      LD1: begin
        dREN  = 1'b1;
        daddr = {miss_tag, miss_idx, 1'b1, 2'b00};
        if (!dwait) next_state = IDLE;
      end
      FLUSH_SCAN: begin
        if (cur.valid && cur.dirty) next_state = FLUSH0;
        else if (cnt == 4'd15)      next_state = DONE;
      end
      DONE:    flushed    = 1'b1;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      miss_tag <= '0;
      miss_idx <= '0;
      vway     <= 1'b0;
      fill0    <= '0;
      cnt      <= '0;
      for (int w = 0; w < WAYS; w++)
        for (int s = 0; s < SETS; s++)
          frames[w][s] <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (dhit && dmemWEN) begin
            frames[hit_way][req.idx].data[req.blkoff] <= dmemstore;
            frames[hit_way][req.idx].dirty            <= 1'b1;
          end
          if (!halt && req_any && !hit_any) begin
            miss_tag <= req.tag;
            miss_idx <= req.idx;
            vway     <= victim;
          end
          cnt <= '0;
        end
        LD0: if (!dwait) fill0 <= dload;
        // The frame is committed only once both words are in hand.
        LD1: if (!dwait) begin
          frames[vway][miss_idx].valid   <= 1'b1;
          frames[vway][miss_idx].dirty   <= 1'b0;
          frames[vway][miss_idx].tag     <= miss_tag;
          frames[vway][miss_idx].data[0] <= fill0;
          frames[vway][miss_idx].data[1] <= dload;
        end
        FLUSH_SCAN: if (!(cur.valid && cur.dirty)) cnt <= cnt + 4'd1;
        FLUSH1: if (!dwait) begin
          frames[sel_way][sel_idx].valid <= 1'b0;
          frames[sel_way][sel_idx].dirty <= 1'b0;
          cnt <= cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_dcache_two_way.sv
// ---------------------------------------------------------------------------
// tb_dcache_two_way : directed scoreboard bench for dcache_two_way
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dcache_two_way;
  localparam int K_HR = 0, K_HW = 1, K_MR = 2, K_MW = 3;

  logic        CLK = 1'b0, nRST = 1'b1, halt = 1'b0;
  logic        dmemREN = 1'b0, dmemWEN = 1'b0;
  logic [31:0] dmemaddr = '0, dmemstore = '0;
  logic        dhit, flushed, dREN, dWEN, dwait;
  logic [31:0] dmemload, daddr, dstore, dload;

  dcache_two_way dut (
    .CLK(CLK), .nRST(nRST), .halt(halt), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit), .dmemload(dmemload),
    .flushed(flushed), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload)
  );

  always #5 CLK = ~CLK;

  // Memory model: each transfer stalls for lat cycles, then completes.
  logic [31:0] mem [0:63];
  int          lat = 1;
  logic [3:0]  wcnt;
  assign dwait = (dREN | dWEN) && (int'(wcnt) < lat);
  assign dload = mem[daddr[7:2]];
  always @(posedge CLK or negedge nRST) begin
    if (!nRST)                        wcnt <= '0;
    else if ((dREN | dWEN) && dwait)  wcnt <= wcnt + 4'd1;
    else                              wcnt <= '0;
  end
  always @(posedge CLK) if (dWEN && !dwait) mem[daddr[7:2]] <= dstore;

  typedef struct { int kind; logic [31:0] addr; logic [31:0] data; } exp_t;
  exp_t q[$];
  int total = 0, bad = 0, nwr = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic push(input int k, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.kind = k; e.addr = a; e.data = d;
    q.push_back(e);
  endtask

  // Monitor: pops one expectation per completed memory transfer or served hit.
  always @(negedge CLK) begin
    exp_t e;
    if (nRST) begin
      if ((dREN || dWEN) && !dwait) begin
        if (dWEN) nwr++;
        check("ren_wen_exclusive", {31'b0, dREN & dWEN}, 32'd0);
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_mem got addr=%h want=no transfer", daddr);
        end else begin
          e = q.pop_front();
          check("mem_kind", dWEN ? K_MW : K_MR, e.kind);
          check("mem_addr", daddr, e.addr);
          if (dWEN) check("mem_wdata", dstore, e.data);
        end
      end
      if (dhit) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_hit got addr=%h want=no hit", dmemaddr);
        end else begin
          e = q.pop_front();
          check("hit_kind", dmemWEN ? K_HW : K_HR, e.kind);
          if (!dmemWEN) check("hit_rdata", dmemload, e.data);
        end
      end
    end
  end

  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output int cyc);
    @(posedge CLK); #1;
    dmemREN = r; dmemWEN = w; dmemaddr = a; dmemstore = d; cyc = 0;
    forever begin
      @(negedge CLK);
      if (dhit) break;
      cyc++;
      if (cyc > 200) begin
        total++; bad++;
        $display("FAIL access_timeout got=no dhit want=dhit addr=%h", a);
        break;
      end
    end
    @(posedge CLK); #1;
    dmemREN = 1'b0; dmemWEN = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge CLK); nRST = 1'b0;
    @(posedge CLK); #1 nRST = 1'b1;
  endtask

  initial begin
    int cyc, base, n;
    for (int i = 0; i < 64; i++) mem[i] = {16'h5A5A, 16'(i)};
    mem[16] = 32'hAAAA_0001; mem[17] = 32'hAAAA_0002;
    mem[32] = 32'hBBBB_0001; mem[33] = 32'hBBBB_0002;
    mem[48] = 32'hCCCC_0001; mem[49] = 32'hCCCC_0002;

    #1 nRST = 1'b0;
    #2;
    check("rst_ctl", {28'b0, dhit, flushed, dREN, dWEN}, 32'd0);
    check("rst_daddr", daddr, 32'd0);
    check("rst_dstore", dstore, 32'd0);
    check("rst_dmemload", dmemload, 32'd0);
    @(posedge CLK); #1 nRST = 1'b1;

    // Cold read, then 0-cycle hits and a write hit.
    push(K_MR, 32'h40, 0); push(K_MR, 32'h44, 0); push(K_HR, 0, 32'hAAAA_0001);
    access(1, 0, 32'h40, 0, cyc);
    push(K_HR, 0, 32'hAAAA_0002);
    access(1, 0, 32'h44, 0, cyc);
    check("hit_latency_rd", cyc, 0);
    push(K_HW, 0, 0);
    access(0, 1, 32'h44, 32'hDEAD_BEEF, cyc);
    check("hit_latency_wr", cyc, 0);
    push(K_HR, 0, 32'hDEAD_BEEF);
    access(1, 0, 32'h44, 0, cyc);

    // Fill second way dirty, touch first way, then evict the dirty one.
    push(K_MR, 32'h80, 0); push(K_MR, 32'h84, 0); push(K_HW, 0, 0);
    access(0, 1, 32'h80, 32'h1234_5678, cyc);
    push(K_HR, 0, 32'hAAAA_0001);
    access(1, 0, 32'h40, 0, cyc);
    check("hit_latency_touch", cyc, 0);
    push(K_MW, 32'h80, 32'h1234_5678); push(K_MW, 32'h84, 32'hBBBB_0002);
    push(K_MR, 32'hC0, 0); push(K_MR, 32'hC4, 0); push(K_HR, 0, 32'hCCCC_0001);
    access(1, 0, 32'hC0, 0, cyc);
    push(K_HR, 0, 32'hDEAD_BEEF);
    access(1, 0, 32'h44, 0, cyc);
    check("hit_latency_kept", cyc, 0);
    check("queue_drained_1", q.size(), 0);

    // Reset during LD1.
    pulse_reset();
    lat = 2;
    push(K_MR, 32'h40, 0);
    @(posedge CLK); #1 dmemREN = 1'b1; dmemaddr = 32'h40;
    n = 0;
    do begin @(negedge CLK); n++; end while (!(dREN && daddr == 32'h44) && n < 50);
    check("reached_ld1", {31'b0, dREN && daddr == 32'h44}, 32'd1);
    nRST = 1'b0;
    #1;
    check("midmiss_rst_ctl", {28'b0, dhit, flushed, dREN, dWEN}, 32'd0);
    check("midmiss_rst_daddr", daddr, 32'd0);
    check("midmiss_rst_dmemload", dmemload, 32'd0);
    dmemREN = 1'b0;
    @(posedge CLK); #1 nRST = 1'b1;
    check("queue_drained_2", q.size(), 0);

    // Re-read misses again; dwait held 5 cycles in LD0.
    lat = 5;
    push(K_MR, 32'h40, 0); push(K_MR, 32'h44, 0); push(K_HR, 0, 32'hAAAA_0001);
    fork
      access(1, 0, 32'h40, 0, cyc);
      begin
        n = 0;
        do begin @(negedge CLK); n++; end while (!dREN && n < 50);
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge CLK);
          check("stall_daddr", daddr, 32'h40);
          check("stall_ctl", {29'b0, dREN, dwait, dhit}, 32'b110);
        end
      end
    join
    lat = 1;

    // Two dirty frames (idx1 way0, idx5 way1), then halt.
    push(K_MR, 32'h48, 0); push(K_MR, 32'h4C, 0); push(K_HW, 0, 0);
    access(0, 1, 32'h48, 32'h1111_1111, cyc);
    push(K_MR, 32'h68, 0); push(K_MR, 32'h6C, 0); push(K_HR, 0, 32'h5A5A_001A);
    access(1, 0, 32'h68, 0, cyc);
    push(K_MR, 32'hA8, 0); push(K_MR, 32'hAC, 0); push(K_HW, 0, 0);
    access(0, 1, 32'hAC, 32'h2222_2222, cyc);
    base = nwr;
    push(K_MW, 32'h48, 32'h1111_1111); push(K_MW, 32'h4C, 32'h5A5A_0013);
    push(K_MW, 32'hA8, 32'h5A5A_002A); push(K_MW, 32'hAC, 32'h2222_2222);
    @(posedge CLK); #1 halt = 1'b1;
    n = 0;
    do begin @(negedge CLK); n++; end while (!flushed && n < 200);
    halt = 1'b0;
    check("flushed_set", {31'b0, flushed}, 32'd1);
    check("flush_writes", nwr - base, 4);
    check("queue_drained_3", q.size(), 0);
    @(posedge CLK); #1 dmemREN = 1'b1; dmemaddr = 32'h40;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("done_hold", {29'b0, flushed, dhit, dREN}, 32'b100);
    end
    dmemREN = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
